// File: rtl/ssd1306_spi_rx_pkg.sv
// Shared definitions for the SSD1306 SPI receiver: opcodes, addressing
// modes, parser states and the argument count of the discarded commands.
package ssd1306_pkg;

  localparam logic [7:0] OP_ADDR_MODE  = 8'h20;
  localparam logic [7:0] OP_COL_ADDR   = 8'h21;
  localparam logic [7:0] OP_PAGE_ADDR  = 8'h22;
  localparam logic [7:0] OP_CONTRAST   = 8'h81;
  localparam logic [7:0] OP_INVERT_OFF = 8'hA6;
  localparam logic [7:0] OP_INVERT_ON  = 8'hA7;
  localparam logic [7:0] OP_DISP_OFF   = 8'hAE;
  localparam logic [7:0] OP_DISP_ON    = 8'hAF;

  localparam logic [7:0] CONTRAST_RESET = 8'h7F;

  typedef enum logic [1:0] {
    HORIZ = 2'd0,
    VERT  = 2'd1,
    PAGE  = 2'd2
  } addr_mode_t;

  typedef enum logic [1:0] {
    CMD  = 2'd0,
    ARG  = 2'd1,
    SKIP = 2'd2
  } parser_state_t;

  // Number of argument bytes that follow a command the receiver ignores.
  function automatic logic [2:0] skip_count(input logic [7:0] opcode);
    logic [2:0] n;
    case (opcode)
      8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB, 8'h8D: n = 3'd1;
      8'hA3:                                           n = 3'd2;
      8'h29, 8'h2A:                                    n = 3'd5;
      8'h26, 8'h27:                                    n = 3'd6;
      default:                                         n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ssd1306_spi_rx_if.sv
// SPI pins from the CPU plus the framebuffer write port. The receiver is
// the slave side; whoever drives the SPI stream uses the master side.
interface ssd1306_spi_rx_if;
  logic       oled_clk;
  logic       oled_data;
  logic       oled_dc;
  logic       fb_we;
  logic [9:0] fb_addr;
  logic [7:0] fb_data;

  modport master (
    output oled_clk, oled_data, oled_dc,
    input  fb_we, fb_addr, fb_data
  );

  modport slave (
    input  oled_clk, oled_data, oled_dc,
    output fb_we, fb_addr, fb_data
  );
endinterface

// File: rtl/ssd1306_spi_rx_spi_byte_rx.sv
// Oversampling SPI byte receiver: synchronises SCK/MOSI/DC into clk_sys,
// detects SCK rising edges and assembles MSB-first bytes. byte_valid is
// combinational so the parser can register its response one cycle later.
module spi_byte_rx (
  input  logic       clock,
  input  logic       reset,
  input  logic       oled_clk,
  input  logic       oled_data,
  input  logic       oled_dc,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc
);

  logic [1:0] sck_sync_q;
  logic [1:0] mosi_sync_q;
  logic [1:0] dc_sync_q;
  logic       sck_prev_q;
  logic [6:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic       rise_s;

  // Synchronisers track the pin level; they are left out of reset so a
  // reset while SCK is high cannot fabricate a rising edge afterwards.
  always_ff @(posedge clock) begin
    sck_sync_q  <= {sck_sync_q[0], oled_clk};
    mosi_sync_q <= {mosi_sync_q[0], oled_data};
    dc_sync_q   <= {dc_sync_q[0], oled_dc};
    sck_prev_q  <= sck_sync_q[1];
  end

  assign rise_s = sck_sync_q[1] & ~sck_prev_q;

  // Shift in one bit per SCK edge; the eighth edge completes a byte.
  always_comb begin
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    byte_valid = 1'b0;
    byte_data  = {shift_q, mosi_sync_q[1]};
    byte_dc    = dc_sync_q[1];
    if (rise_s) begin
      shift_d    = {shift_q[5:0], mosi_sync_q[1]};
      cnt_d      = cnt_q + 3'd1;
      byte_valid = (cnt_q == 3'd7);
    end else begin
      shift_d    = shift_q;
      cnt_d      = cnt_q;
    end
  end

  // Bit counter and partial byte; reset discards any half-received byte.
  always_ff @(posedge clock) begin
    if (reset) begin
      shift_q <= 7'd0;
      cnt_q   <= 3'd0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/ssd1306_spi_rx.sv
// SSD1306 command parser and framebuffer write generator. Command bytes
// drive the parser FSM and display settings; data bytes become writes at
// the current page/column pointer, which then advances inside the window.
module ssd1306_spi_rx
  import ssd1306_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  ssd1306_spi_rx_if.slave        bus,
  output logic                   display_on,
  output logic                   invert,
  output logic [7:0]             contrast,
  output logic                   frame_done
);

  logic       byte_valid_s;
  logic [7:0] byte_data_s;
  logic       byte_dc_s;

  spi_byte_rx u_rx (
    .clock      (clock),
    .reset      (reset),
    .oled_clk   (bus.oled_clk),
    .oled_data  (bus.oled_data),
    .oled_dc    (bus.oled_dc),
    .byte_valid (byte_valid_s),
    .byte_data  (byte_data_s),
    .byte_dc    (byte_dc_s)
  );

  parser_state_t state_q, state_d;
  logic [7:0]    opcode_q, opcode_d;
  logic          arg_idx_q, arg_idx_d;
  logic [2:0]    skip_q, skip_d;
  logic [6:0]    arg0_q, arg0_d;
  addr_mode_t    mode_q, mode_d;
  logic [6:0]    col_start_q, col_start_d, col_end_q, col_end_d, col_q, col_d;
  logic [2:0]    page_start_q, page_start_d, page_end_q, page_end_d, page_q, page_d;
  logic [7:0]    contrast_q, contrast_d;
  logic          display_on_q, display_on_d, invert_q, invert_d;
  logic          fb_we_q, fb_we_d, frame_done_q, frame_done_d;
  logic [9:0]    fb_addr_q, fb_addr_d;
  logic [7:0]    fb_data_q, fb_data_d;

  logic [6:0]    adv_col_s;
  logic [2:0]    adv_page_s;
  logic          adv_wrap_s;

  // Where the pointer goes after a data byte; equality with the end value
  // wraps, so inverted windows still wrap (through the modulo increment).
  always_comb begin
    adv_col_s  = col_q;
    adv_page_s = page_q;
    adv_wrap_s = 1'b0;
    case (mode_q)
      HORIZ: begin
        if (col_q == col_end_q) begin
          adv_col_s = col_start_q;
          if (page_q == page_end_q) begin
            adv_page_s = page_start_q;
            adv_wrap_s = 1'b1;
          end else begin
            adv_page_s = page_q + 3'd1;
          end
        end else begin
          adv_col_s = col_q + 7'd1;
        end
      end
      VERT: begin
        if (page_q == page_end_q) begin
          adv_page_s = page_start_q;
          if (col_q == col_end_q) begin
            adv_col_s  = col_start_q;
            adv_wrap_s = 1'b1;
          end else begin
            adv_col_s = col_q + 7'd1;
          end
        end else begin
          adv_page_s = page_q + 3'd1;
        end
      end
      PAGE: begin
        if (col_q == col_end_q) begin
          adv_col_s = col_start_q;
        end else begin
          adv_col_s = col_q + 7'd1;
        end
      end
      default: begin
        adv_col_s = col_q;
      end
    endcase
  end

  // Parser next state, setting updates and write generation per byte.
  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    arg_idx_d    = arg_idx_q;
    skip_d       = skip_q;
    arg0_d       = arg0_q;
    mode_d       = mode_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    col_d        = col_q;
    page_start_d = page_start_q;
    page_end_d   = page_end_q;
    page_d       = page_q;
    contrast_d   = contrast_q;
    display_on_d = display_on_q;
    invert_d     = invert_q;
    fb_we_d      = 1'b0;
    frame_done_d = 1'b0;
    fb_addr_d    = fb_addr_q;
    fb_data_d    = fb_data_q;

    if (byte_valid_s) begin
      if (byte_dc_s) begin
        // Data bytes are written in any parser state; the state is kept.
        fb_we_d      = 1'b1;
        fb_addr_d    = {page_q, col_q};
        fb_data_d    = byte_data_s;
        col_d        = adv_col_s;
        page_d       = adv_page_s;
        frame_done_d = adv_wrap_s;
      end else begin
        case (state_q)
          CMD: begin
            case (byte_data_s)
              OP_ADDR_MODE, OP_COL_ADDR, OP_PAGE_ADDR, OP_CONTRAST: begin
                state_d   = ARG;
                opcode_d  = byte_data_s;
                arg_idx_d = 1'b0;
              end
              OP_INVERT_OFF: invert_d     = 1'b0;
              OP_INVERT_ON:  invert_d     = 1'b1;
              OP_DISP_OFF:   display_on_d = 1'b0;
              OP_DISP_ON:    display_on_d = 1'b1;
              default: begin
                if (byte_data_s[7:3] == 5'b10110) begin
                  page_d = byte_data_s[2:0];
                end else if (byte_data_s[7:4] == 4'h0) begin
                  col_d = {col_q[6:4], byte_data_s[3:0]};
                end else if (byte_data_s[7:3] == 5'b00010) begin
                  col_d = {byte_data_s[2:0], col_q[3:0]};
                end else if (skip_count(byte_data_s) != 3'd0) begin
                  state_d = SKIP;
                  skip_d  = skip_count(byte_data_s);
                end else begin
                  state_d = CMD;
                end
              end
            endcase
          end
          ARG: begin
            case (opcode_q)
              OP_ADDR_MODE: begin
                if (byte_data_s[1:0] != 2'd3) begin
                  mode_d = addr_mode_t'(byte_data_s[1:0]);
                end else begin
                  mode_d = mode_q;
                end
                state_d = CMD;
              end
              OP_COL_ADDR: begin
                if (arg_idx_q == 1'b0) begin
                  arg0_d    = byte_data_s[6:0];
                  arg_idx_d = 1'b1;
                end else begin
                  col_start_d = arg0_q;
                  col_end_d   = byte_data_s[6:0];
                  col_d       = arg0_q;
                  state_d     = CMD;
                end
              end
              OP_PAGE_ADDR: begin
                if (arg_idx_q == 1'b0) begin
                  arg0_d    = byte_data_s[6:0];
                  arg_idx_d = 1'b1;
                end else begin
                  page_start_d = arg0_q[2:0];
                  page_end_d   = byte_data_s[2:0];
                  page_d       = arg0_q[2:0];
                  state_d      = CMD;
                end
              end
              OP_CONTRAST: begin
                contrast_d = byte_data_s;
                state_d    = CMD;
              end
              default: state_d = CMD;
            endcase
          end
          SKIP: begin
            skip_d = skip_q - 3'd1;
            if (skip_q == 3'd1) begin
              state_d = CMD;
            end else begin
              state_d = SKIP;
            end
          end
          default: state_d = CMD;
        endcase
      end
    end else begin
      fb_we_d = 1'b0;
    end
  end

  // All parser, pointer, setting and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= CMD;
      opcode_q     <= 8'h00;
      arg_idx_q    <= 1'b0;
      skip_q       <= 3'd0;
      arg0_q       <= 7'd0;
      mode_q       <= PAGE;
      col_start_q  <= 7'd0;
      col_end_q    <= 7'd127;
      col_q        <= 7'd0;
      page_start_q <= 3'd0;
      page_end_q   <= 3'd7;
      page_q       <= 3'd0;
      contrast_q   <= CONTRAST_RESET;
      display_on_q <= 1'b0;
      invert_q     <= 1'b0;
      fb_we_q      <= 1'b0;
      frame_done_q <= 1'b0;
      fb_addr_q    <= 10'd0;
      fb_data_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      arg_idx_q    <= arg_idx_d;
      skip_q       <= skip_d;
      arg0_q       <= arg0_d;
      mode_q       <= mode_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      col_q        <= col_d;
      page_start_q <= page_start_d;
      page_end_q   <= page_end_d;
      page_q       <= page_d;
      contrast_q   <= contrast_d;
      display_on_q <= display_on_d;
      invert_q     <= invert_d;
      fb_we_q      <= fb_we_d;
      frame_done_q <= frame_done_d;
      fb_addr_q    <= fb_addr_d;
      fb_data_q    <= fb_data_d;
    end
  end

  assign bus.fb_we   = fb_we_q;
  assign bus.fb_addr = fb_addr_q;
  assign bus.fb_data = fb_data_q;
  assign display_on  = display_on_q;
  assign invert      = invert_q;
  assign contrast    = contrast_q;
  assign frame_done  = frame_done_q;

endmodule
